// File: rtl/csr_trap_pkg.sv
// Shared types and constants for the trap-cause CSR block.
// Cause codes are indexed by source bit; entry 0 is highest priority.
package csr_trap_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PEND    = 2'd1,
      HANDLER = 2'd2
   } state_e;

   localparam logic [11:0] CAUSE_ADDR_DEF = 12'h342;
   localparam logic [11:0] TVAL_ADDR_DEF  = 12'h343;

   // Up to eight sources per class; unused entries read as code 0.
   localparam logic [7:0][7:0] EXC_CODE = {
      8'd0, 8'd0, 8'd0, 8'd0,
      8'd11, 8'd3, 8'd2, 8'd0
   };

   localparam logic [7:0][7:0] IRQ_CODE = {
      8'd0, 8'd0, 8'd0, 8'd0,
      8'd0, 8'd3, 8'd7, 8'd11
   };

endpackage

// File: rtl/csr_trap_cause_if.sv
// CSR set/clear bus plus the trap handshake towards the PC unit.
// The block itself connects through the slave modport.
interface csr_trap_cause_if;

   logic        en_i;
   logic [11:0] addr_i;
   logic [31:0] set_i;
   logic [31:0] clear_i;
   logic        ack_o;
   logic [31:0] value_o;
   logic        trap_valid_o;
   logic        trap_ready_i;
   logic [31:0] trap_cause_o;

   modport master (
      output en_i,
      output addr_i,
      output set_i,
      output clear_i,
      input  ack_o,
      input  value_o,
      input  trap_valid_o,
      output trap_ready_i,
      input  trap_cause_o
   );

   modport slave (
      input  en_i,
      input  addr_i,
      input  set_i,
      input  clear_i,
      output ack_o,
      output value_o,
      output trap_valid_o,
      input  trap_ready_i,
      output trap_cause_o
   );

endinterface

// File: rtl/csr_prio_enc.sv
// Lowest-index-first priority encoder with a valid flag.
// o_idx is zero when no request is set.
module csr_prio_enc #(
   parameter  int N  = 4,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  i_req,
   output logic          o_valid,
   output logic [IW-1:0] o_idx
);

   always_comb begin
      o_idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (i_req[i]) begin
            o_idx = IW'(i);
         end
      end
   end

   assign o_valid = |i_req;

endmodule

// File: rtl/csrfield.sv
// Generic CSR field: hardware capture has priority over a set/clear
// software write; set wins over clear on the same bit.
module csrfield #(
   parameter int           W   = 32,
   parameter logic [W-1:0] RST = '0
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         i_sw_we,
   input  logic [W-1:0] i_set,
   input  logic [W-1:0] i_clear,
   input  logic         i_hw_we,
   input  logic [W-1:0] i_hw_d,
   output logic [W-1:0] o_q
);

   logic [W-1:0] r_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_q <= RST;
      end else if (i_hw_we) begin
         r_q <= i_hw_d;
      end else if (i_sw_we) begin
         r_q <= (r_q & ~i_clear) | i_set;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/csr_trap_cause.sv
// Trap prioritisation with mcause/mtval capture, PC-unit handshake
// and nested-trap depth tracking with a sticky overflow flag.
module csr_trap_cause
   import csr_trap_pkg::*;
#(
   parameter int          NUM_EXC    = 4,
   parameter int          NUM_IRQ    = 3,
   parameter int          CODE_W     = 5,
   parameter int          NEST_MAX   = 2,
   parameter logic [11:0] CAUSE_ADDR = CAUSE_ADDR_DEF,
   parameter logic [11:0] TVAL_ADDR  = TVAL_ADDR_DEF
) (
   input  logic                            clk_i,
   input  logic                            rst_i,
   csr_trap_cause_if.slave                 bus,
   input  logic [NUM_EXC-1:0]              exc_i,
   input  logic [31:0]                     tval_i,
   input  logic [NUM_IRQ-1:0]              irq_i,
   input  logic [NUM_IRQ-1:0]              irq_en_i,
   input  logic                            gie_i,
   input  logic                            mret_i,
   output logic [$clog2(NEST_MAX+1)-1:0]   depth_o,
   output logic                            fatal_o
);

   localparam int DW  = $clog2(NEST_MAX + 1);
   localparam int EIW = (NUM_EXC > 1) ? $clog2(NUM_EXC) : 1;
   localparam int IIW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

   state_e          r_state;
   state_e          w_state_nxt;
   logic [DW-1:0]   r_depth;
   logic [DW-1:0]   w_depth_nxt;
   logic            r_fatal;
   logic            w_fatal_set;

   logic            w_exc_v;
   logic [EIW-1:0]  w_exc_idx;
   logic [NUM_IRQ-1:0] w_irq_q;
   logic            w_irq_v;
   logic [IIW-1:0]  w_irq_idx;
   logic            w_irq_req;
   logic [2:0]      w_exc_sel;
   logic [2:0]      w_irq_sel;
   logic [CODE_W-1:0] w_exc_code;
   logic [CODE_W-1:0] w_irq_code;

   logic            w_cap_exc;
   logic            w_cap_irq;
   logic            w_hw_we;
   logic            w_hw_intr;
   logic [CODE_W-1:0] w_hw_code;
   logic [31:0]     w_hw_tval;

   logic            w_hit_cause;
   logic            w_hit_tval;
   logic            w_intr;
   logic [CODE_W-1:0] w_code;
   logic [31:0]     w_tval;
   logic [31:0]     w_mcause;

   csr_prio_enc #(.N(NUM_EXC)) u_exc_enc (
      .i_req   (exc_i),
      .o_valid (w_exc_v),
      .o_idx   (w_exc_idx)
   );

   assign w_irq_q = irq_i & irq_en_i;

   csr_prio_enc #(.N(NUM_IRQ)) u_irq_enc (
      .i_req   (w_irq_q),
      .o_valid (w_irq_v),
      .o_idx   (w_irq_idx)
   );

   // Only IDLE takes interrupts; HANDLER masks them regardless of gie_i.
   assign w_irq_req  = w_irq_v && gie_i && (r_state == IDLE);
   assign w_exc_sel  = 3'(w_exc_idx);
   assign w_irq_sel  = 3'(w_irq_idx);
   assign w_exc_code = EXC_CODE[w_exc_sel][CODE_W-1:0];
   assign w_irq_code = IRQ_CODE[w_irq_sel][CODE_W-1:0];

   always_comb begin
      w_state_nxt = r_state;
      w_depth_nxt = r_depth;
      w_fatal_set = 1'b0;
      w_cap_exc   = 1'b0;
      w_cap_irq   = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (!r_fatal) begin
               if (w_exc_v) begin
                  w_cap_exc   = 1'b1;
                  w_state_nxt = PEND;
               end else if (w_irq_req) begin
                  w_cap_irq   = 1'b1;
                  w_state_nxt = PEND;
               end
            end
         end
         PEND: begin
            if (bus.trap_ready_i && !r_fatal) begin
               w_depth_nxt = r_depth + DW'(1);
               w_state_nxt = HANDLER;
            end
         end
         HANDLER: begin
            // An exception shadows a coincident mret.
            if (w_exc_v) begin
               if (r_fatal) begin
                  w_fatal_set = 1'b0;
               end else if (r_depth == DW'(NEST_MAX)) begin
                  w_fatal_set = 1'b1;
               end else begin
                  w_cap_exc   = 1'b1;
                  w_state_nxt = PEND;
               end
            end else if (mret_i) begin
               w_depth_nxt = r_depth - DW'(1);
               w_state_nxt = (r_depth == DW'(1)) ? IDLE : HANDLER;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= IDLE;
         r_depth <= '0;
         r_fatal <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_depth <= w_depth_nxt;
         if (w_fatal_set) begin
            r_fatal <= 1'b1;
         end
      end
   end

   assign w_hw_we   = w_cap_exc | w_cap_irq;
   assign w_hw_intr = w_cap_irq;
   assign w_hw_code = w_cap_irq ? w_irq_code : w_exc_code;
   assign w_hw_tval = w_cap_irq ? 32'h0 : tval_i;

   assign w_hit_cause = bus.en_i && (bus.addr_i == CAUSE_ADDR);
   assign w_hit_tval  = bus.en_i && (bus.addr_i == TVAL_ADDR);

   csrfield #(.W(1)) u_cause_intr (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .i_sw_we (w_hit_cause),
      .i_set   (bus.set_i[31]),
      .i_clear (bus.clear_i[31]),
      .i_hw_we (w_hw_we),
      .i_hw_d  (w_hw_intr),
      .o_q     (w_intr)
   );

   csrfield #(.W(CODE_W)) u_cause_code (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .i_sw_we (w_hit_cause),
      .i_set   (bus.set_i[CODE_W-1:0]),
      .i_clear (bus.clear_i[CODE_W-1:0]),
      .i_hw_we (w_hw_we),
      .i_hw_d  (w_hw_code),
      .o_q     (w_code)
   );

   csrfield #(.W(32)) u_tval (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .i_sw_we (w_hit_tval),
      .i_set   (bus.set_i),
      .i_clear (bus.clear_i),
      .i_hw_we (w_hw_we),
      .i_hw_d  (w_hw_tval),
      .o_q     (w_tval)
   );

   assign w_mcause = {w_intr, {(31-CODE_W){1'b0}}, w_code};

   assign bus.ack_o        = w_hit_cause | w_hit_tval;
   assign bus.value_o      = w_hit_cause ? w_mcause :
                             w_hit_tval  ? w_tval   : 32'h0;
   assign bus.trap_valid_o = (r_state == PEND) && !r_fatal;
   assign bus.trap_cause_o = w_mcause;

   assign depth_o = r_depth;
   assign fatal_o = r_fatal;

endmodule

// File: tb/tb_csr_trap_cause.sv
// Directed bench for csr_trap_cause with hand-computed expectations.
// Inputs change 1ns after a rising edge; outputs are checked there too.
module tb_csr_trap_cause;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  exc;
   logic [31:0] tval;
   logic [2:0]  irq;
   logic [2:0]  irq_en;
   logic        gie;
   logic        mret;
   logic [1:0]  depth;
   logic        fatal;

   int n_chk  = 0;
   int n_pass = 0;

   csr_trap_cause_if bus ();

   csr_trap_cause dut (
      .clk_i    (clk),
      .rst_i    (rst),
      .bus      (bus),
      .exc_i    (exc),
      .tval_i   (tval),
      .irq_i    (irq),
      .irq_en_i (irq_en),
      .gie_i    (gie),
      .mret_i   (mret),
      .depth_o  (depth),
      .fatal_o  (fatal)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
   endtask

   task automatic rd(input logic [11:0] a, input string tag,
                     input logic [31:0] exp);
      bus.en_i   = 1'b1;
      bus.addr_i = a;
      #1;
      chk({tag, "_ack"}, 32'(bus.ack_o), 32'd1);
      chk(tag, bus.value_o, exp);
      bus.en_i   = 1'b0;
      #1;
   endtask

   task automatic wr(input logic [11:0] a, input logic [31:0] s,
                     input logic [31:0] c);
      bus.en_i    = 1'b1;
      bus.addr_i  = a;
      bus.set_i   = s;
      bus.clear_i = c;
      tick();
      bus.en_i    = 1'b0;
      bus.set_i   = '0;
      bus.clear_i = '0;
   endtask

   initial begin
      rst = 1'b1; exc = '0; tval = '0; irq = '0; irq_en = '0;
      gie = 1'b0; mret = 1'b0;
      bus.en_i = 1'b0; bus.addr_i = '0; bus.set_i = '0;
      bus.clear_i = '0; bus.trap_ready_i = 1'b0;
      tick(); tick();
      rst = 1'b0;
      tick();

      // reset state
      rd(12'h342, "rst_cause", 32'h0);
      rd(12'h343, "rst_tval", 32'h0);
      chk("rst_valid", 32'(bus.trap_valid_o), 32'd0);
      chk("rst_depth", 32'(depth), 32'd0);
      chk("rst_fatal", 32'(fatal), 32'd0);

      // exception, lowest set bit 1 -> code 2
      exc = 4'b0110; tval = 32'hDEAD_BEEF;
      tick();
      chk("exc_valid", 32'(bus.trap_valid_o), 32'd1);
      chk("exc_cause", bus.trap_cause_o, 32'h0000_0002);
      rd(12'h343, "exc_tval", 32'hDEAD_BEEF);
      bus.trap_ready_i = 1'b1;
      tick();
      bus.trap_ready_i = 1'b0; exc = '0;
      chk("acc_depth", 32'(depth), 32'd1);
      chk("acc_valid", 32'(bus.trap_valid_o), 32'd0);
      mret = 1'b1; tick(); mret = 1'b0;
      chk("mret_depth", 32'(depth), 32'd0);

      // interrupt, lowest qualified bit 1 -> code 7
      irq = 3'b110; irq_en = 3'b111; gie = 1'b1;
      tick();
      chk("irq_valid", 32'(bus.trap_valid_o), 32'd1);
      chk("irq_cause", bus.trap_cause_o, 32'h8000_0007);
      rd(12'h343, "irq_tval", 32'h0);
      bus.trap_ready_i = 1'b1; tick(); bus.trap_ready_i = 1'b0;
      tick();
      chk("irq_masked", 32'(bus.trap_valid_o), 32'd0);
      gie = 1'b0; mret = 1'b1; tick(); mret = 1'b0;
      tick();
      chk("gie_off", 32'(bus.trap_valid_o), 32'd0);
      chk("gie_cause", bus.trap_cause_o, 32'h8000_0007);
      irq = '0;

      // nesting to overflow
      exc = 4'b0100; tval = 32'h0;
      tick();
      chk("n1_cause", bus.trap_cause_o, 32'h0000_0003);
      bus.trap_ready_i = 1'b1; tick(); bus.trap_ready_i = 1'b0;
      exc = 4'b1000; mret = 1'b1;
      tick();
      mret = 1'b0;
      chk("n2_valid", 32'(bus.trap_valid_o), 32'd1);
      chk("n2_cause", bus.trap_cause_o, 32'h0000_000B);
      chk("n2_depth", 32'(depth), 32'd1);
      bus.trap_ready_i = 1'b1; tick(); bus.trap_ready_i = 1'b0;
      exc = '0;
      chk("n2_acc", 32'(depth), 32'd2);
      exc = 4'b0001;
      tick();
      chk("ovf_fatal", 32'(fatal), 32'd1);
      chk("ovf_cause", bus.trap_cause_o, 32'h0000_000B);
      chk("ovf_valid", 32'(bus.trap_valid_o), 32'd0);
      tick();
      chk("ovf_sticky", 32'(fatal), 32'd1);
      rst = 1'b1; tick(); exc = '0; rst = 1'b0;
      chk("clr_fatal", 32'(fatal), 32'd0);
      chk("clr_depth", 32'(depth), 32'd0);
      chk("clr_cause", bus.trap_cause_o, 32'h0);

      // capture beats a same-cycle CSR write
      exc = 4'b0010; tval = 32'h0000_1234;
      wr(12'h342, 32'h8000_001F, 32'h0);
      chk("race_cause", bus.trap_cause_o, 32'h0000_0002);
      bus.trap_ready_i = 1'b1; tick(); bus.trap_ready_i = 1'b0;
      exc = '0;
      mret = 1'b1; tick(); mret = 1'b0;

      // software writes
      wr(12'h342, 32'h8000_001F, 32'h0);
      chk("sw_cause", bus.trap_cause_o, 32'h8000_001F);
      wr(12'h342, 32'h0, 32'h8000_0000);
      chk("sw_clr", bus.trap_cause_o, 32'h0000_001F);
      wr(12'h342, 32'h0000_0001, 32'h0000_001F);
      chk("sw_setwin", bus.trap_cause_o, 32'h0000_0001);
      wr(12'h343, 32'hFFFF_0000, 32'h0);
      rd(12'h343, "sw_tval", 32'hFFFF_1234);
      bus.en_i = 1'b1; bus.addr_i = 12'h300; #1;
      chk("miss_ack", 32'(bus.ack_o), 32'd0);
      chk("miss_val", bus.value_o, 32'h0);
      bus.en_i = 1'b0;
      mret = 1'b1; tick(); mret = 1'b0;
      chk("idle_mret", 32'(depth), 32'd0);

      // reset while pending
      exc = 4'b0001;
      tick();
      chk("mid_valid", 32'(bus.trap_valid_o), 32'd1);
      rst = 1'b1; tick(); exc = '0; rst = 1'b0;
      tick();
      chk("mid_drop", 32'(bus.trap_valid_o), 32'd0);
      chk("mid_depth", 32'(depth), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
